lcd_fb_writer: RTL and testbench

LCD_FB_WRITER -- requirements
Module: lcd_fb_writer

---
 rtl/lcd_fb_writer.sv | 117 +++++++++++
 tb/tb_lcd_fb_writer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_fb_writer.sv
// LCD frame buffer writer: palette-maps PPU pixels, buffers them in a FIFO
// and drains them into a double-buffered frame buffer, swapping on vsync.
module lcd_fb_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int PIX_COUNT  = 23040
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          pix_valid,
  input  logic [14:0]                   pix_addr,
  input  logic [1:0]                    pix_data,
  input  logic                          vsync_in,
  input  logic [7:0]                    bgp,
  output logic [15:0]                   fb_addr,
  output logic [1:0]                    fb_data,
  output logic                          fb_we,
  input  logic                          fb_ready,
  output logic                          disp_bank,
  output logic [15:0]                   frame_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          addr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [15:0]   PIX_LIM  = 16'(PIX_COUNT);

  typedef enum logic {RUN, SWAP_WAIT} state_e;

  logic [16:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          bank_q, bank_d;
  logic [15:0]   fc_q, fc_d;
  logic          ovf_q, ovf_d;
  logic          aerr_q, aerr_d;
  logic          vs_q;
  state_e        state_q, state_d;

  logic          empty, full, addr_ok, pop, push_ok, vs_rise;
  logic [1:0]    shade;
  logic [16:0]   head;

  assign empty   = (level_q == '0);
  assign full    = (level_q == FULL_LVL);
  assign addr_ok = ({1'b0, pix_addr} < PIX_LIM);
  assign pop     = !empty && fb_ready;
  assign push_ok = pix_valid && addr_ok && (!full || pop);
  assign vs_rise = vsync_in && !vs_q;
  assign shade   = bgp[{pix_data, 1'b0} +: 2];
  assign head    = mem_q[rd_ptr_q];

  // Bank bit is attached at pop time so late pixels follow a swap.
  assign fb_we       = !empty;
  assign fb_addr     = empty ? 16'h0 : {~bank_q, head[16:2]};
  assign fb_data     = empty ? 2'h0 : head[1:0];
  assign disp_bank   = bank_q;
  assign frame_count = fc_q;
  assign fifo_level  = level_q;
  assign overflow    = ovf_q;
  assign addr_err    = aerr_q;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push_ok) - LW'(pop);
    ovf_d    = ovf_q || (pix_valid && addr_ok && full && !pop);
    aerr_d   = aerr_q || (pix_valid && !addr_ok);
    state_d  = state_q;
    bank_d   = bank_q;
    fc_d     = fc_q;
    unique case (state_q)
      RUN: begin
        if (vs_rise) state_d = SWAP_WAIT;
      end
      SWAP_WAIT: begin
        if (empty && !push_ok) begin
          state_d = RUN;
          bank_d  = ~bank_q;
          fc_d    = fc_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) mem_q[wr_ptr_q] <= {pix_addr, shade};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      bank_q   <= 1'b0;
      fc_q     <= 16'd0;
      ovf_q    <= 1'b0;
      aerr_q   <= 1'b0;
      vs_q     <= 1'b0;
      state_q  <= RUN;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      bank_q   <= bank_d;
      fc_q     <= fc_d;
      ovf_q    <= ovf_d;
      aerr_q   <= aerr_d;
      vs_q     <= vsync_in;
      state_q  <= state_d;
    end
  end

endmodule

// File: tb/tb_lcd_fb_writer.sv
// Directed self-checking bench for lcd_fb_writer.
// One task per scenario; inputs change 1ns after the rising edge.
module tb_lcd_fb_writer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        pix_valid = 1'b0;
  logic [14:0] pix_addr = '0;
  logic [1:0]  pix_data = '0;
  logic        vsync_in = 1'b0;
  logic [7:0]  bgp = 8'hE4;
  logic [15:0] fb_addr;
  logic [1:0]  fb_data;
  logic        fb_we;
  logic        fb_ready = 1'b0;
  logic        disp_bank;
  logic [15:0] frame_count;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        addr_err;

  int errors = 0;
  int checks = 0;

  lcd_fb_writer #(.FIFO_DEPTH(16), .PIX_COUNT(23040)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .pix_valid(pix_valid), .pix_addr(pix_addr),
    .pix_data(pix_data), .vsync_in(vsync_in), .bgp(bgp),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
    .fb_ready(fb_ready), .disp_bank(disp_bank),
    .frame_count(frame_count), .fifo_level(fifo_level),
    .overflow(overflow), .addr_err(addr_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [14:0] a, input logic [1:0] d);
    pix_valid = 1'b1;
    pix_addr  = a;
    pix_data  = d;
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    fb_ready = 1'b0;
    do_reset();
    checks++;
    if (fifo_level !== 5'd0) begin
      errors++;
      $display("FAIL rst_level got %0d want 0", fifo_level);
    end
    checks++;
    if (fb_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_we got %b want 0", fb_we);
    end
    checks++;
    if (fb_addr !== 16'h0 || fb_data !== 2'd0) begin
      errors++;
      $display("FAIL rst_bus got %h/%0d want 0/0", fb_addr, fb_data);
    end
    checks++;
    if (disp_bank !== 1'b0 || frame_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_bank got %b/%0d want 0/0", disp_bank, frame_count);
    end
    checks++;
    if (overflow !== 1'b0 || addr_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags got %b/%b want 0/0", overflow, addr_err);
    end
  endtask

  task automatic test_single();
    bgp = 8'hE4;
    fb_ready = 1'b1;
    pix_valid = 1'b1;
    pix_addr = 15'd5;
    pix_data = 2'd3;
    checks++;
    if (fb_we !== 1'b0) begin
      errors++;
      $display("FAIL single_same_cycle got %b want 0", fb_we);
    end
    tick();
    pix_valid = 1'b0;
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== 16'h8005 || fb_data !== 2'd3) begin
      errors++;
      $display("FAIL single_write got %b %h %0d want 1 8005 3",
               fb_we, fb_addr, fb_data);
    end
    tick();
    checks++;
    if (fb_we !== 1'b0) begin
      errors++;
      $display("FAIL single_after got %b want 0", fb_we);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] ea;
    logic [1:0]  ed;
    do_reset();
    bgp = 8'h1B;
    fb_ready = 1'b0;
    for (int i = 0; i < 17; i++) push(15'(100 + i), 2'(i));
    checks++;
    if (fifo_level !== 5'd16 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_full got %0d/%b want 16/1", fifo_level, overflow);
    end
    fb_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ea = 16'h8000 | 16'(100 + i);
      ed = 2'(3 - (i % 4));
      checks++;
      if (fb_we !== 1'b1 || fb_addr !== ea || fb_data !== ed) begin
        errors++;
        $display("FAIL ovf_drain%0d got %b %h %0d want 1 %h %0d",
                 i, fb_we, fb_addr, fb_data, ea, ed);
      end
      tick();
    end
    checks++;
    if (fb_we !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_end got %b/%b want 0/1", fb_we, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] ea;
    do_reset();
    bgp = 8'hE4;
    fb_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(15'(200 + i), 2'd1);
    fb_ready = 1'b1;
    push(15'd500, 2'd2);
    checks++;
    if (fifo_level !== 5'd16 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fpp_level got %0d/%b want 16/0", fifo_level, overflow);
    end
    for (int i = 0; i < 16; i++) begin
      ea = (i == 15) ? 16'h81F4 : (16'h8000 | 16'(201 + i));
      checks++;
      if (fb_we !== 1'b1 || fb_addr !== ea) begin
        errors++;
        $display("FAIL fpp_order%0d got %b %h want 1 %h",
                 i, fb_we, fb_addr, ea);
      end
      tick();
    end
    checks++;
    if (fb_we !== 1'b0) begin
      errors++;
      $display("FAIL fpp_empty got %b want 0", fb_we);
    end
  endtask

  task automatic test_swap();
    int n;
    do_reset();
    fb_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(15'(10 + i), 2'd0);
    vsync_in = 1'b1;
    tick();
    tick();
    vsync_in = 1'b0;
    checks++;
    if (disp_bank !== 1'b0 || frame_count !== 16'd0) begin
      errors++;
      $display("FAIL swap_early got %b/%0d want 0/0", disp_bank, frame_count);
    end
    fb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (fb_we !== 1'b1 || fb_addr !== (16'h8000 | 16'(10 + i))) begin
        errors++;
        $display("FAIL swap_write%0d got %b %h want 1 %h",
                 i, fb_we, fb_addr, 16'h8000 | 16'(10 + i));
      end
      tick();
    end
    n = 0;
    while (disp_bank !== 1'b1 && n < 4) begin
      tick();
      n++;
    end
    checks++;
    if (disp_bank !== 1'b1 || frame_count !== 16'd1) begin
      errors++;
      $display("FAIL swap_done got %b/%0d want 1/1", disp_bank, frame_count);
    end
    push(15'd7, 2'd0);
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== 16'h0007) begin
      errors++;
      $display("FAIL swap_newbank got %b %h want 1 0007", fb_we, fb_addr);
    end
    tick();
  endtask

  task automatic test_addr_err_vsync();
    do_reset();
    fb_ready = 1'b1;
    push(15'd23040, 2'd1);
    checks++;
    if (addr_err !== 1'b1 || fifo_level !== 5'd0) begin
      errors++;
      $display("FAIL aerr got %b/%0d want 1/0", addr_err, fifo_level);
    end
    fb_ready = 1'b0;
    push(15'd1, 2'd1);
    push(15'd2, 2'd1);
    for (int k = 0; k < 2; k++) begin
      vsync_in = 1'b1;
      tick();
      vsync_in = 1'b0;
      tick();
    end
    fb_ready = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    checks++;
    if (frame_count !== 16'd1 || disp_bank !== 1'b1) begin
      errors++;
      $display("FAIL dbl_vsync got %0d/%b want 1/1", frame_count, disp_bank);
    end
    checks++;
    if (addr_err !== 1'b1) begin
      errors++;
      $display("FAIL aerr_sticky got %b want 1", addr_err);
    end
  endtask

  task automatic test_reset_mid();
    fb_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(15'(300 + i), 2'd2);
    checks++;
    if (fifo_level !== 5'd8) begin
      errors++;
      $display("FAIL mid_fill got %0d want 8", fifo_level);
    end
    rst_in = 1'b1;
    pix_valid = 1'b1;
    pix_addr = 15'd9;
    tick();
    rst_in = 1'b0;
    pix_valid = 1'b0;
    checks++;
    if (fifo_level !== 5'd0 || fb_we !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got %0d/%b want 0/0", fifo_level, fb_we);
    end
    checks++;
    if (frame_count !== 16'd0 || disp_bank !== 1'b0 || addr_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_state got %0d/%b/%b want 0/0/0",
               frame_count, disp_bank, addr_err);
    end
    fb_ready = 1'b1;
    tick();
    checks++;
    if (fb_we !== 1'b0) begin
      errors++;
      $display("FAIL mid_nowrite got %b want 0", fb_we);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_swap();
    test_addr_err_vsync();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
